// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed/unsigned multiply/divide engine with HI/LO result and reuse cache
module mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  // How FIX produces its result: from the iterated datapath or a shortcut.
  typedef enum logic [1:0] {K_NORM, K_DZ, K_OVF, K_REUSE} kind_t;

  state_t state, state_next;

  // Latched request
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, mag_b_q;
  logic             s_a, s_b;
  kind_t            kind_q;
  logic [CW-1:0]    cnt;

  // Shared iteration registers: product {acc_hi,acc_lo} or {remainder, quotient}
  logic [WIDTH-1:0] acc_hi, acc_lo;

  // One-entry cache of the last completed request
  logic             c_valid;
  logic [1:0]       c_op;
  logic [WIDTH-1:0] c_a, c_b;

  // Request decode (valid in IDLE, uses the live inputs)
  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             req_dz, req_ovf, req_hit, fast_path, accept;
  kind_t            req_kind;

  // Iteration datapath
  logic [WIDTH:0]   mul_add;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] next_hi, next_lo;

  // Final sign correction
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Decode the incoming request into magnitudes, signs and fast-path kind
  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    req_dz    = op[1] && (b == '0);
    req_ovf   = (op == 2'b10) && (a == MIN_NEG) && (b == ALL_ONES);
    req_hit   = REUSE_EN && c_valid && (op == c_op) && (a == c_a) && (b == c_b);
    fast_path = req_dz | req_ovf | req_hit;
    accept    = (state == S_IDLE) && start && !flush;
    req_kind  = K_NORM;
    if (req_dz) begin
      req_kind = K_DZ;
    end else if (req_ovf) begin
      req_kind = K_OVF;
    end else if (req_hit) begin
      req_kind = K_REUSE;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_add   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b_q};
    div_sub   = div_shift[WIDTH-1:0] - mag_b_q;
    if (op_q[1]) begin
      next_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      next_hi = mul_add[WIDTH:1];
      next_lo = {mul_add[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result
  always_comb begin
    prod_res = (s_a ^ s_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_res  = (s_a ^ s_b) ? -acc_lo : acc_lo;
    rem_res  = s_a ? -acc_hi : acc_hi;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and busy; flush always returns to IDLE
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = fast_path ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // Operand latch, iteration, result write-back and cache update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mag_b_q     <= '0;
      s_a         <= 1'b0;
      s_b         <= 1'b0;
      kind_q      <= K_NORM;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      c_valid     <= 1'b0;
      c_op        <= '0;
      c_a         <= '0;
      c_b         <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= b;
        mag_b_q <= mag_b;
        s_a     <= a_neg;
        s_b     <= b_neg;
        kind_q  <= req_kind;
        cnt     <= '0;
        acc_hi  <= '0;
        acc_lo  <= mag_a;
      end
      if (state == S_CALC && !flush) begin
        acc_hi <= next_hi;
        acc_lo <= next_lo;
        cnt    <= cnt + 1'b1;
      end
      if (state == S_FIX && !flush) begin
        done    <= 1'b1;
        c_valid <= 1'b1;
        c_op    <= op_q;
        c_a     <= a_q;
        c_b     <= b_q;
        case (kind_q)
          K_DZ: begin
            hi          <= a_q;
            lo          <= ALL_ONES;
            div_by_zero <= 1'b1;
          end
          K_OVF: begin
            hi          <= '0;
            lo          <= MIN_NEG;
            div_by_zero <= 1'b0;
          end
          K_REUSE: begin
            // hi/lo/div_by_zero already hold this exact request's result
          end
          default: begin
            div_by_zero <= 1'b0;
            if (op_q[1]) begin
              hi <= rem_res;
              lo <= quo_res;
            end else begin
              {hi, lo} <= prod_res;
            end
          end
        endcase
      end
      if (flush) begin
        c_valid <= 1'b0;
      end
    end
  end

endmodule
